multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control sequencer for the datapath. It replaces the single-cycle combinational decoder with a registered FSM that steps each instruction through FETCH, DECODE, EXEC, MEM and WB. Instruction fetch and data memory access both wait on ready/ack handshakes. ALU-op width and machine-code width are parameters. The block sits between instruction memory, the register file/ALU datapath and data memory, and owns PC and IR write enables.

## Interface
Parameters:
- OPWIDTH, 3: ALUOp width, minimum 3; codes are zero-extended.
- MCODEBITS, 4: instruction field width, minimum 4; the opcode is `instr[3:0]` and upper bits are ignored.
- CNT_W, 16: performance counter width.

Ports:
- Clk  in  1  the single clock.
- Reset_n  in  1  asynchronous, active-low reset.
- instr  in  MCODEBITS  machine-code field from instruction memory.
- instr_valid  in  1  instruction memory data valid.
- Zero  in  1  ALU zero flag, sampled in EXEC.
- mem_ack  in  1  data memory has completed the access.
- IRWrite  out  1  latch the instruction.
- PCWrite  out  1  update the PC.
- PCSrc  out  1  1 selects the branch target.
- Branch  out  1  a branch is being evaluated.
- ALUSrc  out  1  1 selects immediate, 0 selects the second register.
- ALUOp  out  OPWIDTH  ALU operation.
- MemRead  out  1  data memory read request.
- MemWrite  out  1  data memory write request.
- MemtoReg  out  1  route memory data to the register file write port.
- RegWrite  out  1  register file write enable.
- Done  out  1  halted.
- cyc_cnt  out  CNT_W  cycle counter (macro only).
- instr_cnt  out  CNT_W  retired-instruction counter (macro only).

## Operation
Opcodes and their classes:
- 0000 store (STORE)
- 0001 add (ALU, ALUOp 000)
- 0010 load (LOAD)
- 0011 sub (ALU, ALUOp 001)
- 0100 and (ALU, ALUOp 010)
- 0101 xor (ALU, ALUOp 011)
- 0110 addi (ALU, ALUOp 000, ALUSrc=1)
- 0111 beqz (BR)
- 1111 halt (HALT)
- All other codes are NOP.

op_q behaviour:
- op_q is loaded from `instr[3:0]` when IRWrite is asserted.
- Reset value of op_q is 1110 (NOP).

State actions and transitions:
- FETCH: IRWrite = instr_valid. If instr_valid, go to DECODE; otherwise stay.
- DECODE: no outputs. If HALT, go to HALT; otherwise go to EXEC.
- EXEC: ALUOp and ALUSrc are driven from op_q. Load and store use ALUOp 000 with ALUSrc=1 for address generation. Transitions by class:
  - ALU goes to WB.
  - LOAD and STORE go to MEM.
  - BR: Branch=1, PCWrite=1, PCSrc=Zero, then go to FETCH.
  - NOP: PCWrite=1, then go to FETCH.
- MEM: MemRead (LOAD) or MemWrite (STORE) is held until mem_ack. On mem_ack, LOAD goes to WB. On mem_ack, STORE asserts PCWrite in the same cycle and goes to FETCH.
- WB: RegWrite=1 and PCWrite=1; MemtoReg=1 for LOAD. Then go to FETCH.
- HALT: Done=1 and all other outputs are 0. The state is sticky until reset.

General rules:
- ALUOp in every state other than EXEC is 111 (pass a).
- Outputs not listed for a state are 0.
- Reset values: state FETCH, op_q 1110, every output 0 (including counters). IRWrite is additionally gated by Reset_n.

## Timing
Latency in cycles, with zero-wait handshakes:
- ALU op and store: 4.
- Load: 5.
- Branch and NOP: 3.
- Halt: FETCH, DECODE, then HALT.

Cycle-level behaviour:
- Every wait cycle on instr_valid or mem_ack adds exactly one cycle.
- FETCH→DECODE and MEM exit are Mealy transitions on the handshake input sampled at the same edge.
- MemRead and MemWrite stay stable from MEM entry until the cycle mem_ack is high, inclusive.
- mem_ack outside MEM and instr_valid outside FETCH are ignored.
- Zero is sampled only in EXEC.
- Asynchronous reset mid-operation forces FETCH immediately, deasserts all outputs combinationally and abandons any pending memory access.
- PCWrite pulses exactly once per retired non-halt instruction.

## Configuration
- Macro: CTRL_PERF_CNT_EN.
- When defined:
  - cyc_cnt increments every cycle out of reset, including HALT, and saturates at all-ones.
  - instr_cnt increments on each PCWrite pulse and on HALT entry, and saturates.
- When undefined: cyc_cnt and instr_cnt are tied to 0 and no counter flops are built.

## Structure
- Package ctrl_pkg holds:
  - state enum: FETCH, DECODE, EXEC, MEM, WB, HALT;
  - instruction class enum: ALU, LOAD, STORE, BR, NOP, HALT;
  - opcode localparams;
  - ALUOp code localparams.
- Sub-module ctrl_decode is purely combinational. It maps op_q to class, ALUOp and ALUSrc. The FSM lives in multicycle_control.

## Test plan
- Reset then add (0001), instr_valid=1 -> IRWrite@c0, EXEC ALUOp=000 ALUSrc=0, WB RegWrite=1 PCWrite=1, back in FETCH at c4.
- Load (0010) with mem_ack delayed 3 cycles -> MemRead high for 4 cycles, WB MemtoReg=1 RegWrite=1, total 8 cycles.
- Store (0000), ack in first MEM cycle -> MemWrite and PCWrite in the same cycle, RegWrite never high.
- beqz (0111) with Zero=1, then again with Zero=0 -> PCSrc=1, then PCSrc=0; PCWrite=1 and Branch=1 both times, 3 cycles each.
- Halt (1111), then toggle instr_valid -> Done=1 sticky, no IRWrite. Reset_n pulse returns to FETCH with Done=0.
- CTRL_PERF_CNT_EN with CNT_W=4, 20 NOPs -> instr_cnt saturates at 15, cyc_cnt saturates at 15. Reset asserted mid-MEM -> MemRead drops immediately, counters clear to 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multi-cycle control sequencer.
//   state_e   - sequencer states (FETCH, DECODE, EXEC, MEM, WB, HALT)
//   iclass_e  - instruction classes produced by ctrl_decode
//   OPC_*     - 4-bit opcodes taken from instr[3:0]
//   ALUOP_*   - 3-bit ALU operation codes, zero-extended to OPWIDTH by users
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BR,
        CL_NOP,
        CL_HALT
    } iclass_e;

    localparam logic [3:0] OPC_STORE = 4'b0000;
    localparam logic [3:0] OPC_ADD   = 4'b0001;
    localparam logic [3:0] OPC_LOAD  = 4'b0010;
    localparam logic [3:0] OPC_SUB   = 4'b0011;
    localparam logic [3:0] OPC_AND   = 4'b0100;
    localparam logic [3:0] OPC_XOR   = 4'b0101;
    localparam logic [3:0] OPC_ADDI  = 4'b0110;
    localparam logic [3:0] OPC_BEQZ  = 4'b0111;
    localparam logic [3:0] OPC_HALT  = 4'b1111;
    // Reset value of the latched opcode; decodes as NOP.
    localparam logic [3:0] OPC_RESET = 4'b1110;

    localparam logic [2:0] ALUOP_ADD  = 3'b000;
    localparam logic [2:0] ALUOP_SUB  = 3'b001;
    localparam logic [2:0] ALUOP_AND  = 3'b010;
    localparam logic [2:0] ALUOP_XOR  = 3'b011;
    localparam logic [2:0] ALUOP_PASS = 3'b111;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational opcode decoder.
//   op_i     - latched opcode (op_q of the sequencer)
//   cls_o    - instruction class
//   aluop_o  - ALU operation for the EXEC state, zero-extended to OPWIDTH
//   alusrc_o - 1 selects the immediate operand in EXEC
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned OPWIDTH = 3
) (
    input  logic [3:0]         op_i,
    output iclass_e            cls_o,
    output logic [OPWIDTH-1:0] aluop_o,
    output logic               alusrc_o
);

    logic [2:0] aluop3;

    always_comb begin
        cls_o    = CL_NOP;
        aluop3   = ALUOP_PASS;
        alusrc_o = 1'b0;
        case (op_i)
            OPC_ADD:  begin cls_o = CL_ALU; aluop3 = ALUOP_ADD; end
            OPC_SUB:  begin cls_o = CL_ALU; aluop3 = ALUOP_SUB; end
            OPC_AND:  begin cls_o = CL_ALU; aluop3 = ALUOP_AND; end
            OPC_XOR:  begin cls_o = CL_ALU; aluop3 = ALUOP_XOR; end
            OPC_ADDI: begin cls_o = CL_ALU; aluop3 = ALUOP_ADD; alusrc_o = 1'b1; end
            // Memory ops use the ALU for base + immediate address generation.
            OPC_LOAD:  begin cls_o = CL_LOAD;  aluop3 = ALUOP_ADD; alusrc_o = 1'b1; end
            OPC_STORE: begin cls_o = CL_STORE; aluop3 = ALUOP_ADD; alusrc_o = 1'b1; end
            // beqz only needs the register passed through for the zero test.
            OPC_BEQZ: cls_o = CL_BR;
            OPC_HALT: cls_o = CL_HALT;
            default:  cls_o = CL_NOP;
        endcase
        aluop_o = OPWIDTH'(aluop3);
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: registered FETCH/DECODE/EXEC/MEM/WB sequencer that owns
// the PC and IR write enables and steers the register file, ALU and data memory.
//   Clk, Reset_n            - clock, asynchronous active-low reset
//   instr, instr_valid      - instruction memory data and valid handshake
//   Zero                    - ALU zero flag, used only in EXEC
//   mem_ack                 - data memory completion handshake
//   IRWrite, PCWrite, PCSrc, Branch, ALUSrc, ALUOp,
//   MemRead, MemWrite, MemtoReg, RegWrite, Done - datapath controls
//   cyc_cnt, instr_cnt      - saturating performance counters
// Optional feature: define CTRL_PERF_CNT_EN to build the performance counters;
// otherwise both counter outputs are tied to zero.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int unsigned OPWIDTH   = 3,
    parameter int unsigned MCODEBITS = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [MCODEBITS-1:0] instr,
    input  logic                 instr_valid,
    input  logic                 Zero,
    input  logic                 mem_ack,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 PCSrc,
    output logic                 Branch,
    output logic                 ALUSrc,
    output logic [OPWIDTH-1:0]   ALUOp,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 Done,
    output logic [CNT_W-1:0]     cyc_cnt,
    output logic [CNT_W-1:0]     instr_cnt
);

    localparam logic [OPWIDTH-1:0] ALUOP_PASS_W = OPWIDTH'(ALUOP_PASS);

    state_e               state_q, state_d;
    logic [3:0]           op_q;
    iclass_e              dec_cls;
    logic [OPWIDTH-1:0]   dec_aluop;
    logic                 dec_alusrc;

    ctrl_decode #(
        .OPWIDTH(OPWIDTH)
    ) u_decode (
        .op_i    (op_q),
        .cls_o   (dec_cls),
        .aluop_o (dec_aluop),
        .alusrc_o(dec_alusrc)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_FETCH;
            op_q    <= OPC_RESET;
        end else begin
            state_q <= state_d;
            if (IRWrite) begin
                op_q <= instr[3:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        Branch   = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = '0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        Done     = 1'b0;
        // While reset is held every output stays low, including IRWrite.
        if (Reset_n) begin
            ALUOp = ALUOP_PASS_W;
            unique case (state_q)
                ST_FETCH: begin
                    IRWrite = instr_valid;
                    if (instr_valid) begin
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_d = (dec_cls == CL_HALT) ? ST_HALT : ST_EXEC;
                end
                ST_EXEC: begin
                    ALUOp  = dec_aluop;
                    ALUSrc = dec_alusrc;
                    case (dec_cls)
                        CL_ALU:            state_d = ST_WB;
                        CL_LOAD, CL_STORE: state_d = ST_MEM;
                        CL_BR: begin
                            Branch  = 1'b1;
                            PCWrite = 1'b1;
                            PCSrc   = Zero;
                            state_d = ST_FETCH;
                        end
                        default: begin
                            PCWrite = 1'b1;
                            state_d = ST_FETCH;
                        end
                    endcase
                end
                ST_MEM: begin
                    MemRead  = (dec_cls == CL_LOAD);
                    MemWrite = (dec_cls == CL_STORE);
                    if (mem_ack) begin
                        if (dec_cls == CL_LOAD) begin
                            state_d = ST_WB;
                        end else begin
                            // Store retires in its ack cycle; no writeback.
                            PCWrite = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_WB: begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                    MemtoReg = (dec_cls == CL_LOAD);
                    state_d  = ST_FETCH;
                end
                ST_HALT: begin
                    ALUOp = '0;
                    Done  = 1'b1;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_cnt_q;
    logic [CNT_W-1:0] instr_cnt_q;
    logic             halt_entry;

    assign halt_entry = (state_q == ST_DECODE) && (state_d == ST_HALT);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cyc_cnt_q   <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (cyc_cnt_q != '1) begin
                cyc_cnt_q <= cyc_cnt_q + 1'b1;
            end
            if ((PCWrite || halt_entry) && (instr_cnt_q != '1)) begin
                instr_cnt_q <= instr_cnt_q + 1'b1;
            end
        end
    end

    assign cyc_cnt   = cyc_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    assign cyc_cnt   = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Per-cycle expected output
// vectors are queued together with their stimulus and compared one cycle at
// a time. Counter checks follow CTRL_PERF_CNT_EN.
module tb_multicycle_control;

    localparam int unsigned OPW = 3;
    localparam int unsigned MCB = 4;
    localparam int unsigned CW  = 4;

    logic           Clk = 1'b0;
    logic           Reset_n = 1'b0;
    logic [MCB-1:0] instr = '0;
    logic           instr_valid = 1'b0;
    logic           Zero = 1'b0;
    logic           mem_ack = 1'b0;
    logic           IRWrite, PCWrite, PCSrc, Branch, ALUSrc;
    logic [OPW-1:0] ALUOp;
    logic           MemRead, MemWrite, MemtoReg, RegWrite, Done;
    logic [CW-1:0]  cyc_cnt, instr_cnt;

    multicycle_control #(
        .OPWIDTH  (OPW),
        .MCODEBITS(MCB),
        .CNT_W    (CW)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .instr      (instr),
        .instr_valid(instr_valid),
        .Zero       (Zero),
        .mem_ack    (mem_ack),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCSrc      (PCSrc),
        .Branch     (Branch),
        .ALUSrc     (ALUSrc),
        .ALUOp      (ALUOp),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .Done       (Done),
        .cyc_cnt    (cyc_cnt),
        .instr_cnt  (instr_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       irw, pcw, pcsrc, br, alusrc;
        logic [2:0] aluop;
        logic       mrd, mwr, m2r, rw, done;
    } out_t;

    typedef struct packed {
        logic [3:0] op;
        logic       iv, z, ack;
    } stim_t;

    typedef struct packed {
        stim_t s;
        out_t  e;
        out_t  m;
    } step_t;

    localparam out_t ALL = '1;
    localparam logic [3:0] ALU_OPS [5] = '{4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b0110};
    localparam logic [2:0] ALU_EXP [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b000};
    localparam logic       ALU_SRC [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    step_t sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    out_t  got;

    assign got = {IRWrite, PCWrite, PCSrc, Branch, ALUSrc, ALUOp,
                  MemRead, MemWrite, MemtoReg, RegWrite, Done};

    // Output vector of a non-EXEC, non-HALT state with nothing asserted.
    function automatic out_t idle();
        out_t o = '0;
        o.aluop = 3'b111;
        return o;
    endfunction

    function automatic stim_t st(logic [3:0] op, logic iv, logic z, logic ack);
        stim_t s;
        s.op = op; s.iv = iv; s.z = z; s.ack = ack;
        return s;
    endfunction

    function automatic void push(stim_t s, out_t e, out_t m);
        step_t t;
        t.s = s; t.e = e; t.m = m;
        sb_q.push_back(t);
    endfunction

    function automatic out_t fetch_hit();
        out_t o = idle();
        o.irw = 1'b1;
        return o;
    endfunction

    // Queue a NOP-class instruction: FETCH, DECODE, EXEC with a PCWrite pulse.
    function automatic void push_nop(logic [3:0] op);
        out_t e = idle();
        out_t m = ALL;
        push(st(op, 1'b1, 1'b0, 1'b0), fetch_hit(), ALL);
        push(st(4'b1111, 1'b1, 1'b1, 1'b1), idle(), ALL);
        e.pcw = 1'b1;
        m.aluop = '0;
        m.alusrc = 1'b0;
        push(st(4'b0000, 1'b0, 1'b1, 1'b1), e, m);
    endfunction

    task automatic test_reset();
        @(negedge Clk);
        #1;
        n_checks++;
        if (got !== out_t'('0)) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected all zero", got);
        end
        n_checks++;
        if (cyc_cnt !== '0 || instr_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_counters: got cyc=%0d instr=%0d, expected 0/0", cyc_cnt, instr_cnt);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        instr_valid = 1'b0;
    endtask

    task automatic test_alu();
        step_t t;
        out_t  e;
        int    cyc = 0;
        // Idle FETCH cycles: stray ack and Zero must have no effect.
        push(st(4'b0001, 1'b0, 1'b1, 1'b1), idle(), ALL);
        push(st(4'b0001, 1'b0, 1'b1, 1'b1), idle(), ALL);
        for (int i = 0; i < 5; i++) begin
            push(st(ALU_OPS[i], 1'b1, 1'b0, 1'b0), fetch_hit(), ALL);
            push(st(4'b1111, 1'b1, 1'b0, 1'b1), idle(), ALL);
            e = '0;
            e.aluop = ALU_EXP[i];
            e.alusrc = ALU_SRC[i];
            push(st(4'b0010, 1'b1, 1'b1, 1'b1), e, ALL);
            e = idle();
            e.rw = 1'b1;
            e.pcw = 1'b1;
            push(st(4'b0000, 1'b1, 1'b0, 1'b1), e, ALL);
        end
        while (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            @(negedge Clk);
            instr = t.s.op; instr_valid = t.s.iv; Zero = t.s.z; mem_ack = t.s.ack;
            #1;
            n_checks++;
            if ((got & t.m) !== (t.e & t.m)) begin
                n_fail++;
                $display("FAIL alu cyc%0d: got %b, expected %b (mask %b)", cyc, got, t.e, t.m);
            end
            cyc++;
        end
    endtask

    task automatic test_load();
        step_t t;
        out_t  e;
        int    cyc = 0;
        push(st(4'b0010, 1'b1, 1'b0, 1'b0), fetch_hit(), ALL);
        push(st(4'b0000, 1'b0, 1'b0, 1'b1), idle(), ALL);
        e = '0;
        e.aluop = 3'b000;
        e.alusrc = 1'b1;
        push(st(4'b0000, 1'b1, 1'b1, 1'b1), e, ALL);
        e = idle();
        e.mrd = 1'b1;
        push(st(4'b0000, 1'b1, 1'b0, 1'b0), e, ALL);
        push(st(4'b0000, 1'b1, 1'b1, 1'b0), e, ALL);
        push(st(4'b0000, 1'b1, 1'b0, 1'b0), e, ALL);
        push(st(4'b0000, 1'b1, 1'b0, 1'b1), e, ALL);
        e = idle();
        e.rw = 1'b1;
        e.pcw = 1'b1;
        e.m2r = 1'b1;
        push(st(4'b0000, 1'b1, 1'b0, 1'b1), e, ALL);
        push(st(4'b0000, 1'b0, 1'b0, 1'b1), idle(), ALL);
        while (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            @(negedge Clk);
            instr = t.s.op; instr_valid = t.s.iv; Zero = t.s.z; mem_ack = t.s.ack;
            #1;
            n_checks++;
            if ((got & t.m) !== (t.e & t.m)) begin
                n_fail++;
                $display("FAIL load cyc%0d: got %b, expected %b (mask %b)", cyc, got, t.e, t.m);
            end
            cyc++;
        end
    endtask

    task automatic test_store();
        step_t t;
        out_t  e;
        int    cyc = 0;
        push(st(4'b0000, 1'b1, 1'b0, 1'b0), fetch_hit(), ALL);
        push(st(4'b0001, 1'b1, 1'b0, 1'b1), idle(), ALL);
        e = '0;
        e.aluop = 3'b000;
        e.alusrc = 1'b1;
        push(st(4'b0001, 1'b1, 1'b0, 1'b1), e, ALL);
        e = idle();
        e.mwr = 1'b1;
        e.pcw = 1'b1;
        push(st(4'b0001, 1'b0, 1'b0, 1'b1), e, ALL);
        push(st(4'b0001, 1'b0, 1'b0, 1'b1), idle(), ALL);
        while (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            @(negedge Clk);
            instr = t.s.op; instr_valid = t.s.iv; Zero = t.s.z; mem_ack = t.s.ack;
            #1;
            n_checks++;
            if ((got & t.m) !== (t.e & t.m)) begin
                n_fail++;
                $display("FAIL store cyc%0d: got %b, expected %b (mask %b)", cyc, got, t.e, t.m);
            end
            cyc++;
        end
    endtask

    task automatic test_branch();
        step_t t;
        out_t  e;
        out_t  m;
        int    cyc = 0;
        for (int z = 1; z >= 0; z--) begin
            push(st(4'b0111, 1'b1, ~z[0], 1'b0), fetch_hit(), ALL);
            push(st(4'b0001, 1'b1, ~z[0], 1'b1), idle(), ALL);
            e = idle();
            e.br = 1'b1;
            e.pcw = 1'b1;
            e.pcsrc = z[0];
            m = ALL;
            m.aluop = '0;
            m.alusrc = 1'b0;
            push(st(4'b0001, 1'b1, z[0], 1'b1), e, m);
        end
        push_nop(4'b1000);
        push_nop(4'b1110);
        while (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            @(negedge Clk);
            instr = t.s.op; instr_valid = t.s.iv; Zero = t.s.z; mem_ack = t.s.ack;
            #1;
            n_checks++;
            if ((got & t.m) !== (t.e & t.m)) begin
                n_fail++;
                $display("FAIL branch_nop cyc%0d: got %b, expected %b (mask %b)", cyc, got, t.e, t.m);
            end
            cyc++;
        end
    endtask

    task automatic test_halt();
        step_t t;
        out_t  h = '0;
        int    cyc = 0;
        h.done = 1'b1;
        push(st(4'b1111, 1'b1, 1'b0, 1'b0), fetch_hit(), ALL);
        push(st(4'b0001, 1'b0, 1'b0, 1'b0), idle(), ALL);
        for (int i = 0; i < 4; i++) begin
            push(st(4'b0001, i[0], 1'b1, 1'b1), h, ALL);
        end
        while (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            @(negedge Clk);
            instr = t.s.op; instr_valid = t.s.iv; Zero = t.s.z; mem_ack = t.s.ack;
            #1;
            n_checks++;
            if ((got & t.m) !== (t.e & t.m)) begin
                n_fail++;
                $display("FAIL halt cyc%0d: got %b, expected %b (mask %b)", cyc, got, t.e, t.m);
            end
            cyc++;
        end
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        n_checks++;
        if (got !== out_t'('0)) begin
            n_fail++;
            $display("FAIL halt_reset_hold: got %b, expected all zero", got);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        instr_valid = 1'b0;
        mem_ack = 1'b0;
        @(negedge Clk);
        #1;
        n_checks++;
        if (got !== idle()) begin
            n_fail++;
            $display("FAIL halt_released: got %b, expected %b", got, idle());
        end
    endtask

    task automatic test_reset_mid_mem();
        step_t t;
        out_t  e;
        int    cyc = 0;
        push(st(4'b0010, 1'b1, 1'b0, 1'b0), fetch_hit(), ALL);
        push(st(4'b0010, 1'b0, 1'b0, 1'b0), idle(), ALL);
        e = '0;
        e.aluop = 3'b000;
        e.alusrc = 1'b1;
        push(st(4'b0010, 1'b0, 1'b0, 1'b0), e, ALL);
        e = idle();
        e.mrd = 1'b1;
        push(st(4'b0010, 1'b0, 1'b0, 1'b0), e, ALL);
        push(st(4'b0010, 1'b0, 1'b0, 1'b0), e, ALL);
        while (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            @(negedge Clk);
            instr = t.s.op; instr_valid = t.s.iv; Zero = t.s.z; mem_ack = t.s.ack;
            #1;
            n_checks++;
            if ((got & t.m) !== (t.e & t.m)) begin
                n_fail++;
                $display("FAIL mem_reset cyc%0d: got %b, expected %b (mask %b)", cyc, got, t.e, t.m);
            end
            cyc++;
        end
        // Assert reset between clock edges while MemRead is held.
        #2;
        Reset_n = 1'b0;
        #1;
        n_checks++;
        if (got !== out_t'('0)) begin
            n_fail++;
            $display("FAIL mem_reset_async: got %b, expected all zero", got);
        end
        n_checks++;
        if (cyc_cnt !== '0 || instr_cnt !== '0) begin
            n_fail++;
            $display("FAIL mem_reset_counters: got cyc=%0d instr=%0d, expected 0/0", cyc_cnt, instr_cnt);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        instr_valid = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            #1;
            n_checks++;
            if (got !== idle()) begin
                n_fail++;
                $display("FAIL mem_reset_abandon %0d: got %b, expected %b", i, got, idle());
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_perf();
`ifdef CTRL_PERF_CNT_EN
        step_t t;
        out_t  h = '0;
        int    cyc = 0;
        h.done = 1'b1;
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        instr_valid = 1'b0;
        push_nop(4'b1001);
        push(st(4'b1111, 1'b1, 1'b0, 1'b0), fetch_hit(), ALL);
        push(st(4'b0000, 1'b0, 1'b0, 1'b0), idle(), ALL);
        push(st(4'b0000, 1'b0, 1'b0, 1'b0), h, ALL);
        while (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            @(negedge Clk);
            instr = t.s.op; instr_valid = t.s.iv; Zero = t.s.z; mem_ack = t.s.ack;
            #1;
            n_checks++;
            if ((got & t.m) !== (t.e & t.m)) begin
                n_fail++;
                $display("FAIL perf_seq cyc%0d: got %b, expected %b (mask %b)", cyc, got, t.e, t.m);
            end
            cyc++;
        end
        n_checks++;
        if (cyc_cnt !== CW'(6) || instr_cnt !== CW'(2)) begin
            n_fail++;
            $display("FAIL perf_halt_entry: got cyc=%0d instr=%0d, expected 6/2", cyc_cnt, instr_cnt);
        end
        @(negedge Clk);
        #1;
        n_checks++;
        if (cyc_cnt !== CW'(7) || instr_cnt !== CW'(2)) begin
            n_fail++;
            $display("FAIL perf_in_halt: got cyc=%0d instr=%0d, expected 7/2", cyc_cnt, instr_cnt);
        end
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_nop(4'b1010);
        end
        cyc = 0;
        while (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            @(negedge Clk);
            instr = t.s.op; instr_valid = t.s.iv; Zero = t.s.z; mem_ack = t.s.ack;
            #1;
            n_checks++;
            if ((got & t.m) !== (t.e & t.m)) begin
                n_fail++;
                $display("FAIL perf_nops cyc%0d: got %b, expected %b (mask %b)", cyc, got, t.e, t.m);
            end
            cyc++;
        end
        n_checks++;
        if (cyc_cnt !== CW'(15) || instr_cnt !== CW'(15)) begin
            n_fail++;
            $display("FAIL perf_saturate: got cyc=%0d instr=%0d, expected 15/15", cyc_cnt, instr_cnt);
        end
`else
        @(negedge Clk);
        #1;
        n_checks++;
        if (cyc_cnt !== '0 || instr_cnt !== '0) begin
            n_fail++;
            $display("FAIL perf_tied_off: got cyc=%0d instr=%0d, expected 0/0", cyc_cnt, instr_cnt);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_halt();
        test_reset_mid_mem();
        test_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
